// File: rtl/fltflt_engine_if.sv
// Request/done handshake plus byte-wide memory master bus of the half-precision adder.
// The master modport is the engine side; the slave modport is the requester/memory side.
interface fltflt_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req,
    input  mem_rdata,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wdata
  );

  modport slave (
    output req,
    output mem_rdata,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wdata
  );
endinterface

// File: rtl/fltflt_engine.sv
// Half-precision (1/5/10) sign-magnitude adder: on req low it fetches two operands
// from memory, adds them with truncation, writes the sum back and holds done until req rises.
module fltflt_engine #(
  parameter int BASE_ADDR = 128,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  fltflt_engine_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK,
    S_WR_HI,
    S_WR_LO,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [2:0]        rd_cnt;
  logic [DATA_W-1:0] a1_hi, a1_lo, a2_hi, a2_lo;

  logic              s_l_p1;
  logic              sub_p1;
  logic [4:0]        e_l_p1;
  logic [10:0]       m_l_p1;
  logic [10:0]       m_s_p1;

  logic              res_s_p2;
  logic [5:0]        res_e_p2;
  logic [10:0]       res_m_p2;

  logic [15:0]       result_p3;

  logic [15:0]       op1, op2;
  logic [4:0]        e1, e2, e_l, e_s, d;
  logic [10:0]       m1, m2, m_l, m_s, m_s_sh;
  logic              op1_big, s_l;

  logic [11:0]       sum12;
  logic [10:0]       diff11;
  logic [10:0]       add_m, norm_m;
  logic [5:0]        add_e, norm_e;

  // Subnormals share the scale of exponent 1 so they align against normals correctly.
  function automatic logic [4:0] eff_exp(input logic [4:0] e);
    return (e == 5'd0) ? 5'd1 : e;
  endfunction

  function automatic logic norm_need(input logic [10:0] m, input logic [5:0] e);
    return (!m[10]) && (m != 11'd0) && (e > 6'd1);
  endfunction

  function automatic logic [15:0] pack_result(input logic s, input logic [5:0] e,
                                              input logic [10:0] m);
    logic [15:0] r;
    if (m == 11'd0)
      r = 16'h0000;
    else if (e > 6'd31)
      r = {s, 5'h1F, 10'h3FF};
    else
      r = {s, (m[10] ? e[4:0] : 5'd0), m[9:0]};
    return r;
  endfunction

  always_comb begin
    op1     = {a1_hi, a1_lo};
    op2     = {a2_hi, a2_lo};
    e1      = op1[14:10];
    e2      = op2[14:10];
    m1      = {|e1, op1[9:0]};
    m2      = {|e2, op2[9:0]};
    op1_big = ({e1, m1} >= {e2, m2});
    s_l     = op1_big ? op1[15] : op2[15];
    e_l     = op1_big ? eff_exp(e1) : eff_exp(e2);
    e_s     = op1_big ? eff_exp(e2) : eff_exp(e1);
    m_l     = op1_big ? m1 : m2;
    m_s     = op1_big ? m2 : m1;
    d       = e_l - e_s;
    m_s_sh  = (d >= 5'd11) ? 11'd0 : (m_s >> d);
  end

  always_comb begin
    sum12  = {1'b0, m_l_p1} + {1'b0, m_s_p1};
    diff11 = m_l_p1 - m_s_p1;
    add_e  = {1'b0, e_l_p1};
    add_m  = diff11;
    if (!sub_p1) begin
      if (sum12[11]) begin
        add_m = sum12[11:1];
        add_e = {1'b0, e_l_p1} + 6'd1;
      end else begin
        add_m = sum12[10:0];
      end
    end
    norm_m = {res_m_p2[9:0], 1'b0};
    norm_e = res_e_p2 - 6'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.done      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (!bus.req)
          state_nx = S_RD;
      end
      S_RD: begin
        bus.mem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'((rd_cnt > 3'd3) ? 3'd3 : rd_cnt);
        if (rd_cnt == 3'd4)
          state_nx = S_ALIGN;
      end
      S_ALIGN: state_nx = S_ADD;
      S_ADD:   state_nx = norm_need(add_m, add_e) ? S_NORM : S_PACK;
      S_NORM:  state_nx = norm_need(norm_m, norm_e) ? S_NORM : S_PACK;
      S_PACK:  state_nx = S_WR_HI;
      S_WR_HI: begin
        bus.mem_addr  = ADDR_W'(BASE_ADDR + 4);
        bus.mem_wdata = result_p3[15:8];
        bus.mem_wr_en = 1'b1;
        state_nx      = S_WR_LO;
      end
      S_WR_LO: begin
        bus.mem_addr  = ADDR_W'(BASE_ADDR + 5);
        bus.mem_wdata = result_p3[7:0];
        bus.mem_wr_en = 1'b1;
        state_nx      = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.req)
          state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt    <= '0;
      a1_hi     <= '0;
      a1_lo     <= '0;
      a2_hi     <= '0;
      a2_lo     <= '0;
      s_l_p1    <= 1'b0;
      sub_p1    <= 1'b0;
      e_l_p1    <= '0;
      m_l_p1    <= '0;
      m_s_p1    <= '0;
      res_s_p2  <= 1'b0;
      res_e_p2  <= '0;
      res_m_p2  <= '0;
      result_p3 <= '0;
    end else begin
      case (state)
        S_IDLE: rd_cnt <= '0;
        // fetch: byte for address k arrives while address k+1 is presented
        S_RD: begin
          rd_cnt <= rd_cnt + 3'd1;
          case (rd_cnt)
            3'd1:    a1_hi <= bus.mem_rdata;
            3'd2:    a1_lo <= bus.mem_rdata;
            3'd3:    a2_hi <= bus.mem_rdata;
            3'd4:    a2_lo <= bus.mem_rdata;
            default: ;
          endcase
        end
        // p1: operands ordered and the smaller mantissa aligned
        S_ALIGN: begin
          s_l_p1 <= s_l;
          sub_p1 <= op1[15] ^ op2[15];
          e_l_p1 <= e_l;
          m_l_p1 <= m_l;
          m_s_p1 <= m_s_sh;
        end
        // p2: magnitude add/subtract, carry renormalised in place
        S_ADD: begin
          res_s_p2 <= s_l_p1;
          res_e_p2 <= add_e;
          res_m_p2 <= add_m;
        end
        S_NORM: begin
          res_e_p2 <= norm_e;
          res_m_p2 <= norm_m;
        end
        // p3: encoded result held for the two write beats
        S_PACK: result_p3 <= pack_result(res_s_p2, res_e_p2, res_m_p2);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fltflt_engine.sv
// Bench for fltflt_engine: byte memory model, arithmetic reference adder,
// directed, randomized, abort and done-hold scenarios.
module tb_fltflt_engine;

  localparam int BASE = 128;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   wr_count;
  logic [7:0] mem [256];

  logic [15:0] dir_a [6];
  logic [15:0] dir_b [6];
  logic [15:0] dir_r [6];
  int          dir_lat [6];

  fltflt_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  fltflt_engine #(.BASE_ADDR(BASE), .ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      wr_count = wr_count + 1;
    end
  end

  // Value-level reference: magnitudes as integers scaled by 2^exp, truncating alignment.
  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                            output int n);
    int ea, eb, ma, mb, el, es, ml, ms, d, m, e;
    logic sl, sub;
    logic [4:0] ef;
    logic [9:0] mf;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = ((ea != 0) ? 1024 : 0) + int'(a[9:0]);
    mb = ((eb != 0) ? 1024 : 0) + int'(b[9:0]);
    if (ea > eb || (ea == eb && ma >= mb)) begin
      el = ea; ml = ma; es = eb; ms = mb; sl = a[15];
    end else begin
      el = eb; ml = mb; es = ea; ms = ma; sl = b[15];
    end
    sub = a[15] ^ b[15];
    if (el == 0) el = 1;
    if (es == 0) es = 1;
    d  = el - es;
    ms = (d >= 11) ? 0 : ms / (1 << d);
    m  = sub ? ml - ms : ml + ms;
    e  = el;
    n  = 0;
    if (m >= 2048) begin
      m = m / 2;
      e = e + 1;
    end
    while (m < 1024 && m != 0 && e > 1) begin
      m = m * 2;
      e = e - 1;
      n = n + 1;
    end
    if (m == 0) return 16'h0000;
    if (e > 31) return {sl, 15'h7FFF};
    ef = (m >= 1024) ? 5'(e) : 5'd0;
    mf = 10'(m % 1024);
    return {sl, ef, mf};
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] got, output int lat, output int writes);
    @(negedge clk);
    mem[BASE]   = a[15:8];
    mem[BASE+1] = a[7:0];
    mem[BASE+2] = b[15:8];
    mem[BASE+3] = b[7:0];
    mem[BASE+4] = 8'hEE;
    mem[BASE+5] = 8'hEE;
    wr_count    = 0;
    bus.req     = 1'b0;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    got    = {mem[BASE+4], mem[BASE+5]};
    writes = wr_count;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", bus.done);
    end
    checks++;
    if (bus.mem_wr_en !== 1'b0) begin
      failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.mem_wr_en);
    end
    checks++;
    if (bus.mem_addr !== 8'h00) begin
      failures++; $display("FAIL reset_addr got=%h exp=00", bus.mem_addr);
    end
    checks++;
    if (bus.mem_wdata !== 8'h00) begin
      failures++; $display("FAIL reset_wdata got=%h exp=00", bus.mem_wdata);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL idle_hold_done got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_directed();
    logic [15:0] got;
    int lat, writes;
    dir_a   = '{16'h1A04, 16'h4A10, 16'h3C00, 16'h3C00, 16'h7BFF, 16'h0400};
    dir_b   = '{16'h1A04, 16'h4204, 16'hB800, 16'hBC00, 16'h7BFF, 16'h8001};
    dir_r   = '{16'h1E04, 16'h4B91, 16'h3800, 16'h0000, 16'h7FFF, 16'h03FF};
    dir_lat = '{10, 10, 11, 10, 10, 10};
    for (int i = 0; i < 6; i++) begin
      run_op(dir_a[i], dir_b[i], got, lat, writes);
      checks++;
      if (got !== dir_r[i]) begin
        failures++;
        $display("FAIL directed_result %h+%h got=%h exp=%h", dir_a[i], dir_b[i], got, dir_r[i]);
      end
      checks++;
      if (lat != dir_lat[i]) begin
        failures++;
        $display("FAIL directed_latency %h+%h got=%0d exp=%0d", dir_a[i], dir_b[i], lat, dir_lat[i]);
      end
      checks++;
      if (writes != 2) begin
        failures++; $display("FAIL directed_writes got=%0d exp=2", writes);
      end
      @(negedge clk);
      bus.req = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.done !== 1'b0) begin
        failures++; $display("FAIL directed_done_release got=%b exp=0", bus.done);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] r1, r2;
    logic [15:0] a, b, got, exp_r;
    int lat, writes, n;
    for (int i = 0; i < 40; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      a  = r1[15:0];
      case (i % 4)
        0:       b = r2[15:0];
        1:       b = {~a[15], a[14:10], r2[9:0]};
        2:       b = {r2[15], a[14:11], r2[10:0]};
        default: b = {r2[15], 5'd0, r2[9:0]};
      endcase
      exp_r = model_add(a, b, n);
      run_op(a, b, got, lat, writes);
      checks++;
      if (got !== exp_r) begin
        failures++; $display("FAIL random_result %h+%h got=%h exp=%h", a, b, got, exp_r);
      end
      checks++;
      if (lat != 10 + n || writes != 2) begin
        failures++;
        $display("FAIL random_timing %h+%h lat=%0d writes=%0d exp_lat=%0d exp_writes=2",
                 a, b, lat, writes, 10 + n);
      end
      @(negedge clk);
      bus.req = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] got, exp_r;
    int lat, writes, n, bad_done;
    @(negedge clk);
    mem[BASE]   = 8'h7C;
    mem[BASE+1] = 8'h01;
    mem[BASE+2] = 8'hFC;
    mem[BASE+3] = 8'h00;
    mem[BASE+4] = 8'hA5;
    mem[BASE+5] = 8'h5A;
    wr_count    = 0;
    bus.req     = 1'b0;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.mem_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_outputs done=%b wr_en=%b exp=0/0", bus.done, bus.mem_wr_en);
    end
    @(negedge clk);
    reset    = 1'b1;
    bad_done = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) bad_done++;
    end
    checks++;
    if (wr_count != 0 || bad_done != 0) begin
      failures++;
      $display("FAIL abort_quiet writes=%0d done_cycles=%0d exp=0/0", wr_count, bad_done);
    end
    checks++;
    if ({mem[BASE+4], mem[BASE+5]} !== 16'hA55A) begin
      failures++; $display("FAIL abort_mem got=%h exp=a55a", {mem[BASE+4], mem[BASE+5]});
    end
    exp_r = model_add(16'h7C01, 16'hFC00, n);
    run_op(16'h7C01, 16'hFC00, got, lat, writes);
    checks++;
    if (got !== exp_r || lat != 10 + n) begin
      failures++;
      $display("FAIL abort_restart got=%h lat=%0d exp=%h lat=%0d", got, lat, exp_r, 10 + n);
    end
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_done_hold();
    logic [15:0] got, exp_r;
    int lat, writes, n, low_cycles;
    logic [31:0] r1, r2;
    run_op(16'h4A10, 16'h4204, got, lat, writes);
    low_cycles = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b1) low_cycles++;
    end
    checks++;
    if (low_cycles != 0 || wr_count != 2) begin
      failures++;
      $display("FAIL hold_done low_cycles=%0d writes=%0d exp=0/2", low_cycles, wr_count);
    end
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL hold_release got=%b exp=0", bus.done);
    end
    r1 = $urandom;
    r2 = $urandom;
    exp_r = model_add(r1[15:0], r2[15:0], n);
    run_op(r1[15:0], r2[15:0], got, lat, writes);
    checks++;
    if (got !== exp_r || lat != 10 + n) begin
      failures++;
      $display("FAIL hold_second_op got=%h lat=%0d exp=%h lat=%0d", got, lat, exp_r, 10 + n);
    end
    @(negedge clk);
    bus.req = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_count = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_directed();
    test_random();
    test_reset_abort();
    test_done_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
